seg7_scan: RTL and testbench

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_pkg.sv | 36 +++
 rtl/seg7_decode.sv | 27 ++
 rtl/seg7_scan.sv | 192 +++++++++++++++++++
 tb/tb_seg7_scan.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the two-digit seven-segment scanner.
package seg7_pkg;

  // Scan sequence: a dark dead-time before each digit slot stops ghosting.
  typedef enum logic [1:0] {
    BLANK_T = 2'd0,
    SHOW_T  = 2'd1,
    BLANK_U = 2'd2,
    SHOW_U  = 2'd3
  } state_e;

  // Segment patterns, active-low, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;

  // Digit enables, active-low: [1] = tens, [0] = units.
  localparam logic [1:0] DIG_NONE  = 2'b11;
  localparam logic [1:0] DIG_TENS  = 2'b01;
  localparam logic [1:0] DIG_UNITS = 2'b10;

  // True for the dead-time states.
  function automatic logic is_blank_state(input state_e s);
    return (s == BLANK_T) || (s == BLANK_U);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low seven-segment pattern; non-BCD codes show a dash.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_n_o
);

  // Pure lookup; values 10..15 are flagged to the viewer as a dash.
  always_comb begin
    seg_n_o = SEG_DASH;
    case (digit_i)
      4'd0:    seg_n_o = SEG_0;
      4'd1:    seg_n_o = SEG_1;
      4'd2:    seg_n_o = SEG_2;
      4'd3:    seg_n_o = SEG_3;
      4'd4:    seg_n_o = SEG_4;
      4'd5:    seg_n_o = SEG_5;
      4'd6:    seg_n_o = SEG_6;
      4'd7:    seg_n_o = SEG_7;
      4'd8:    seg_n_o = SEG_8;
      4'd9:    seg_n_o = SEG_9;
      default: seg_n_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Two-digit multiplexed seven-segment driver with dead-time, leading-zero
// blanking and frame-synchronous blink. Digits are captured once per frame
// so a display refresh never mixes old and new values.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned BLANK_CYC = 16,
  parameter int unsigned BLINK_DIV = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bcd_tens,
  input  logic [3:0] bcd_units,
  input  logic       blink,
  output logic [6:0] seg_n,
  output logic [1:0] dig_n,
  output logic       frame_tick
);

  localparam int unsigned CW       = $clog2(SCAN_DIV);
  localparam int unsigned SHOW_CYC = SCAN_DIV - BLANK_CYC;
  localparam int unsigned BW       = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            slot_end_s;
  logic            frame_end_s;

  logic [3:0]      tens_q, units_q;

  logic            blink_en_q;
  logic            blink_phase_q;   // 1 = lit half of the blink period
  logic [BW-1:0]   blink_cnt_q;
  logic            dark_s;

  logic [3:0]      dec_in_s;
  logic [6:0]      dec_seg_s;

  logic [6:0]      seg_d, seg_q;
  logic [1:0]      dig_d, dig_q;
  logic            tick_d, tick_q;

  // Detect the last cycle of the current slot and of the whole frame.
  always_comb begin
    slot_end_s  = 1'b0;
    frame_end_s = 1'b0;
    if (is_blank_state(state_q)) begin
      slot_end_s = (cnt_q == BLANK_LAST);
    end else begin
      slot_end_s = (cnt_q == SHOW_LAST);
    end
    frame_end_s = (state_q == SHOW_U) && slot_end_s;
  end

  // Next-state logic: advance through the four slots, restarting the counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (slot_end_s) begin
      cnt_d = {CW{1'b0}};
      case (state_q)
        BLANK_T: state_d = SHOW_T;
        SHOW_T:  state_d = BLANK_U;
        BLANK_U: state_d = SHOW_U;
        SHOW_U:  state_d = BLANK_T;
        default: state_d = BLANK_T;
      endcase
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State and slot counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BLANK_T;
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the digits once per frame, on its final cycle, to avoid tearing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tens_q  <= 4'd0;
      units_q <= 4'd0;
    end else if (frame_end_s) begin
      tens_q  <= bcd_tens;
      units_q <= bcd_units;
    end
  end

  // Blink request is sampled at frame ends; the phase flips every BLINK_DIV
  // blinking frames and restarts lit whenever blinking is off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_en_q    <= 1'b0;
      blink_phase_q <= 1'b1;
      blink_cnt_q   <= {BW{1'b0}};
    end else if (frame_end_s) begin
      blink_en_q <= blink;
      if (!blink) begin
        blink_phase_q <= 1'b1;
        blink_cnt_q   <= {BW{1'b0}};
      end else if (blink_en_q) begin
        if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_q   <= {BW{1'b0}};
          blink_phase_q <= ~blink_phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + BW'(1);
        end
      end else begin
        blink_phase_q <= 1'b1;
        blink_cnt_q   <= {BW{1'b0}};
      end
    end
  end

  assign dark_s = blink_en_q && !blink_phase_q;

  // Select which held digit feeds the shared decoder for the upcoming slot.
  always_comb begin
    dec_in_s = units_q;
    if (state_d == SHOW_T) begin
      dec_in_s = tens_q;
    end else begin
      dec_in_s = units_q;
    end
  end

  seg7_decode u_decode (
    .digit_i (dec_in_s),
    .seg_n_o (dec_seg_s)
  );

  // Outputs are computed for the next state so they are valid in its first cycle.
  always_comb begin
    seg_d  = SEG_OFF;
    dig_d  = DIG_NONE;
    tick_d = 1'b0;
    case (state_d)
      SHOW_T: begin
        if (!dark_s && (tens_q != 4'd0)) begin
          dig_d = DIG_TENS;
          seg_d = dec_seg_s;
        end else begin
          dig_d = DIG_NONE;
          seg_d = SEG_OFF;
        end
      end
      SHOW_U: begin
        if (!dark_s) begin
          dig_d = DIG_UNITS;
          seg_d = dec_seg_s;
        end else begin
          dig_d = DIG_NONE;
          seg_d = SEG_OFF;
        end
        tick_d = (cnt_d == SHOW_LAST);
      end
      default: begin
        dig_d = DIG_NONE;
        seg_d = SEG_OFF;
      end
    endcase
  end

  // Registered display outputs and frame pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q  <= SEG_OFF;
      dig_q  <= DIG_NONE;
      tick_q <= 1'b0;
    end else begin
      seg_q  <= seg_d;
      dig_q  <= dig_d;
      tick_q <= tick_d;
    end
  end

  assign seg_n      = seg_q;
  assign dig_n      = dig_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan against a frame-position reference model.
module tb_seg7_scan;

  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;
  localparam int BLINK_DIV = 2;
  localparam int FRAME     = 2 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] bcd_tens = 4'd0;
  logic [3:0] bcd_units = 4'd0;
  logic       blink = 1'b0;
  logic [6:0] seg_n;
  logic [1:0] dig_n;
  logic       frame_tick;

  always #5 clk = ~clk;

  seg7_scan #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .rst(rst), .bcd_tens(bcd_tens), .bcd_units(bcd_units), .blink(blink),
    .seg_n(seg_n), .dig_n(dig_n), .frame_tick(frame_tick)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: cycle position in frame, held digits, blink run.
  int         pos;
  logic [3:0] m_tens, m_units;
  bit         run_active;
  int         run_idx;
  logic [1:0] ed;
  logic [6:0] es, em;
  logic       et;

  function automatic logic [6:0] pat(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic model_reset();
    pos = 0; m_tens = 4'd0; m_units = 4'd0; run_active = 1'b0; run_idx = 0;
  endtask

  // Expected outputs for the current frame position.
  task automatic compute_exp();
    bit dark;
    dark = run_active && (((run_idx / BLINK_DIV) % 2) == 1);
    ed = 2'b11; es = 7'h7F; em = 7'h7F; et = (pos == FRAME - 1);
    if (pos >= BLANK_CYC && pos < SCAN_DIV) begin
      if (!dark && m_tens != 4'd0) begin ed = 2'b01; es = pat(m_tens); end
      else em = 7'h00;
    end else if (pos >= SCAN_DIV + BLANK_CYC) begin
      if (!dark) begin ed = 2'b10; es = pat(m_units); end
      else em = 7'h00;
    end
  endtask

  // Advance one clock; at frame end the model takes the inputs present at that edge.
  task automatic step();
    if (pos == FRAME - 1) begin
      m_tens = bcd_tens; m_units = bcd_units;
      if (blink) begin
        if (run_active) run_idx++; else run_idx = 0;
        run_active = 1'b1;
      end else begin
        run_active = 1'b0;
      end
    end
    @(posedge clk);
    pos = (pos + 1) % FRAME;
    @(negedge clk);
    compute_exp();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_assert++;
    if ({seg_n, dig_n, frame_tick} !== {7'h7F, 2'b11, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_hold seg_n=%b dig_n=%b tick=%b expected 1111111 11 0", seg_n, dig_n, frame_tick);
    end
    rst = 1'b0;
    model_reset();
    compute_exp();
    n_assert++;
    if ({dig_n, seg_n & em, frame_tick} !== {ed, es & em, et}) begin
      n_fail++;
      $display("FAIL reset_release dig_n=%b seg_n=%b tick=%b expected %b %b %b", dig_n, seg_n, frame_tick, ed, es, et);
    end
  endtask

  task automatic test_basic();
    bcd_tens = 4'd4; bcd_units = 4'd2; blink = 1'b0;
    repeat (3 * FRAME) begin
      step();
      n_assert++;
      if ({dig_n, seg_n & em, frame_tick} !== {ed, es & em, et}) begin
        n_fail++;
        $display("FAIL basic pos=%0d dig_n=%b seg_n=%b tick=%b expected %b %b %b", pos, dig_n, seg_n, frame_tick, ed, es, et);
      end
    end
  endtask

  task automatic test_leading_zero();
    bcd_tens = 4'd0; bcd_units = 4'd7;
    repeat (2 * FRAME + 1) begin
      step();
      n_assert++;
      if ({dig_n, seg_n & em, frame_tick} !== {ed, es & em, et}) begin
        n_fail++;
        $display("FAIL leading_zero pos=%0d dig_n=%b seg_n=%b tick=%b expected %b %b %b", pos, dig_n, seg_n, frame_tick, ed, es, et);
      end
    end
  endtask

  task automatic test_dash();
    bcd_tens = 4'd11; bcd_units = 4'd15;
    repeat (2 * FRAME + 1) begin
      step();
      n_assert++;
      if ({dig_n, seg_n & em, frame_tick} !== {ed, es & em, et}) begin
        n_fail++;
        $display("FAIL dash pos=%0d dig_n=%b seg_n=%b tick=%b expected %b %b %b", pos, dig_n, seg_n, frame_tick, ed, es, et);
      end
    end
  endtask

  task automatic test_no_tearing();
    bcd_tens = 4'd9; bcd_units = 4'd8;
    repeat (FRAME) step();
    // Move to cycle 3 of the tens slot, then change both digits.
    for (int i = 0; i < 2 * FRAME && pos != BLANK_CYC + 3; i++) begin
      step();
      n_assert++;
      if ({dig_n, seg_n & em, frame_tick} !== {ed, es & em, et}) begin
        n_fail++;
        $display("FAIL tearing_pre pos=%0d dig_n=%b seg_n=%b expected %b %b", pos, dig_n, seg_n, ed, es);
      end
    end
    n_assert++;
    if (pos != BLANK_CYC + 3) begin
      n_fail++;
      $display("FAIL tearing_align pos=%0d expected %0d", pos, BLANK_CYC + 3);
    end
    bcd_tens = 4'd3; bcd_units = 4'd6;
    repeat (2 * FRAME + 2) begin
      step();
      n_assert++;
      if ({dig_n, seg_n & em, frame_tick} !== {ed, es & em, et}) begin
        n_fail++;
        $display("FAIL tearing pos=%0d dig_n=%b seg_n=%b tick=%b expected %b %b %b", pos, dig_n, seg_n, frame_tick, ed, es, et);
      end
    end
  endtask

  task automatic test_blink();
    bcd_tens = 4'd5; bcd_units = 4'd1;
    repeat (5) step();
    blink = 1'b1;                 // raised mid-frame: takes effect next frame
    repeat (8 * FRAME) begin
      step();
      n_assert++;
      if ({dig_n, seg_n & em, frame_tick} !== {ed, es & em, et}) begin
        n_fail++;
        $display("FAIL blink_on pos=%0d run=%0d dig_n=%b seg_n=%b expected %b %b", pos, run_idx, dig_n, seg_n, ed, es);
      end
    end
    repeat (4) step();
    blink = 1'b0;
    repeat (2 * FRAME) begin
      step();
      n_assert++;
      if ({dig_n, seg_n & em, frame_tick} !== {ed, es & em, et}) begin
        n_fail++;
        $display("FAIL blink_off pos=%0d dig_n=%b seg_n=%b expected %b %b", pos, dig_n, seg_n, ed, es);
      end
    end
  endtask

  task automatic test_random();
    repeat (10 * FRAME) begin
      if ($urandom_range(7) == 0) begin
        bcd_tens  = 4'($urandom);
        bcd_units = 4'($urandom);
      end
      if ($urandom_range(19) == 0) blink = ~blink;
      step();
      n_assert++;
      if ({dig_n, seg_n & em, frame_tick} !== {ed, es & em, et}) begin
        n_fail++;
        $display("FAIL random pos=%0d dig_n=%b seg_n=%b tick=%b expected %b %b %b", pos, dig_n, seg_n, frame_tick, ed, es, et);
      end
    end
    blink = 1'b0;
  endtask

  task automatic test_async_reset();
    bcd_tens = 4'd7; bcd_units = 4'd3;
    repeat (2 * FRAME) step();
    for (int i = 0; i < FRAME && pos != SCAN_DIV + BLANK_CYC + 2; i++) step();
    n_assert++;
    if (dig_n !== 2'b10) begin
      n_fail++;
      $display("FAIL async_pre dig_n=%b expected 10", dig_n);
    end
    #1 rst = 1'b1;
    #1;
    n_assert++;
    if ({seg_n, dig_n, frame_tick} !== {7'h7F, 2'b11, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset seg_n=%b dig_n=%b tick=%b expected 1111111 11 0", seg_n, dig_n, frame_tick);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    compute_exp();
    repeat (FRAME + 1) begin
      step();
      n_assert++;
      if ({dig_n, seg_n & em, frame_tick} !== {ed, es & em, et}) begin
        n_fail++;
        $display("FAIL async_restart pos=%0d dig_n=%b seg_n=%b tick=%b expected %b %b %b", pos, dig_n, seg_n, frame_tick, ed, es, et);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_leading_zero();
    test_dash();
    test_no_tearing();
    test_blink();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
